// File: rtl/rf_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : rf_spi_tx
// Purpose  : Serialises a frame of N_WORDS 24-bit words to an RF synthesiser
//            over a 3-wire SPI-style link (SCLK / DATA / LE), MSB first.
//            Each word is pulled from an external word source, shifted out,
//            latched with an LE pulse, and followed by a one-cycle gap.
// Ports    : clk        - single clock, rising edge
//            RSTn       - asynchronous active-low reset
//            start      - frame request, sampled only while idle
//            data_in    - current word from the word source
//            next_word  - one-cycle pulse that advances the word source
//            spi_sclk   - serial clock, idles low
//            spi_data   - serial data, changes only while spi_sclk is low
//            spi_le     - load-enable pulse after each word
//            busy       - frame in progress (first LOAD through DONE)
//            done       - one-cycle pulse at frame end
// Revision : 1.0 - initial release
// ============================================================================
module rf_spi_tx #(
    parameter int N_WORDS = 6,
    parameter int HALF    = 2,
    parameter int LE_CYC  = 2
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        start,
    input  logic [23:0] data_in,
    output logic        next_word,
    output logic        spi_sclk,
    output logic        spi_data,
    output logic        spi_le,
    output logic        busy,
    output logic        done
);

    // The division counter times both the SCLK period and the LE pulse.
    localparam int c_DIV_MAX = (2 * HALF > LE_CYC) ? 2 * HALF : LE_CYC;
    localparam int c_DIV_W   = $clog2(c_DIV_MAX) + 1;

    localparam logic [c_DIV_W-1:0] c_HALF    = c_DIV_W'(HALF);
    localparam logic [c_DIV_W-1:0] c_PER_END = c_DIV_W'(2 * HALF - 1);
    localparam logic [c_DIV_W-1:0] c_LE_END  = c_DIV_W'(LE_CYC - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);
    localparam logic [3:0]         c_NWORDS  = 4'(N_WORDS);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_SHIFT = 3'd2;
    localparam logic [2:0] c_S_LATCH = 3'd3;
    localparam logic [2:0] c_S_GAP   = 3'd4;
    localparam logic [2:0] c_S_DONE  = 3'd5;

    logic [2:0]         r_state, w_state;
    logic [c_DIV_W-1:0] r_div,   w_div;
    logic [4:0]         r_bit,   w_bit;
    logic [3:0]         r_word,  w_word;
    logic [23:0]        r_shreg, w_shreg;
    logic               r_sclk,  w_sclk;
    logic               r_le,    w_le;
    logic               r_nw,    w_nw;
    logic               r_busy,  w_busy;
    logic               r_done,  w_done;
    logic [c_DIV_W-1:0] w_div_inc;
    logic [3:0]         w_word_inc;

    assign w_div_inc  = r_div + c_DIV_ONE;
    assign w_word_inc = r_word + 4'd1;

    // Next-state logic. Output values are computed for the state being
    // entered so that every output is a flop aligned with its state.
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_word  = r_word;
        w_shreg = r_shreg;
        w_sclk  = 1'b0;
        w_le    = 1'b0;
        w_nw    = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state = c_S_LOAD;
                    w_word  = 4'd0;
                    w_nw    = 1'b1;
                end else begin
                    w_busy  = 1'b0;
                end
            end
            c_S_LOAD: begin
                // The source only advances on the edge ending LOAD, so the
                // word captured here is still the one it was asked for.
                w_state = c_S_SHIFT;
                w_shreg = data_in;
                w_div   = '0;
                w_bit   = 5'd23;
            end
            c_S_SHIFT: begin
                if (r_div == c_PER_END) begin
                    w_div = '0;
                    if (r_bit == 5'd0) begin
                        // No shift after the last bit: DATA stays on bit 0
                        // while LE is high.
                        w_state = c_S_LATCH;
                        w_le    = 1'b1;
                    end else begin
                        w_bit   = r_bit - 5'd1;
                        w_shreg = {r_shreg[22:0], 1'b0};
                    end
                end else begin
                    w_div  = w_div_inc;
                    w_sclk = (w_div_inc >= c_HALF);
                end
            end
            c_S_LATCH: begin
                if (r_div == c_LE_END) begin
                    w_state = c_S_GAP;
                    w_div   = '0;
                end else begin
                    w_div = w_div_inc;
                    w_le  = 1'b1;
                end
            end
            c_S_GAP: begin
                w_word = w_word_inc;
                if (w_word_inc < c_NWORDS) begin
                    w_state = c_S_LOAD;
                    w_nw    = 1'b1;
                end else begin
                    w_state = c_S_DONE;
                    w_done  = 1'b1;
                end
            end
            c_S_DONE: begin
                w_state = c_S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = c_S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= c_S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_word  <= '0;
            r_shreg <= '0;
            r_sclk  <= 1'b0;
            r_le    <= 1'b0;
            r_nw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_word  <= w_word;
            r_shreg <= w_shreg;
            r_sclk  <= w_sclk;
            r_le    <= w_le;
            r_nw    <= w_nw;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign next_word = r_nw;
    assign spi_sclk  = r_sclk;
    assign spi_data  = r_shreg[23];
    assign spi_le    = r_le;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rf_spi_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rf_spi_tx
// Purpose  : Self-checking bench for rf_spi_tx. A default-parameter instance
//            is driven from a word-source model and observed by an SPI
//            receiver model; a second instance (1 word, HALF=1, LE_CYC=1)
//            covers the shortest timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_spi_tx;

    localparam int c_N    = 6;
    localparam int c_H    = 2;
    localparam int c_LE   = 2;
    localparam int c_WLEN = 1 + 48 * c_H + c_LE + 1;
    localparam int c_FLEN = c_N * c_WLEN;

    localparam logic [23:0] c_W32 [0:5] = '{24'h043420, 24'h28BB85, 24'h1F1902,
                                            24'h00C0A1, 24'h200016, 24'h00FA03};

    logic        clk  = 1'b0;
    logic        RSTn = 1'b0;

    // default instance
    logic        start_a = 1'b0;
    logic [23:0] din_a;
    logic        nw_a, sclk_a, data_a, le_a, busy_a, done_a;

    // short-timing instance
    logic        start_b = 1'b0;
    logic [23:0] din_b = 24'hFFFFFF;
    logic        nw_b, sclk_b, data_b, le_b, busy_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rf_spi_tx dut_a (
        .clk(clk), .RSTn(RSTn), .start(start_a), .data_in(din_a),
        .next_word(nw_a), .spi_sclk(sclk_a), .spi_data(data_a),
        .spi_le(le_a), .busy(busy_a), .done(done_a)
    );

    rf_spi_tx #(.N_WORDS(1), .HALF(1), .LE_CYC(1)) dut_b (
        .clk(clk), .RSTn(RSTn), .start(start_b), .data_in(din_b),
        .next_word(nw_b), .spi_sclk(sclk_b), .spi_data(data_b),
        .spi_le(le_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- word source model ----------------
    logic [23:0] src_mem [0:7];
    int          src_ptr = 0;
    logic        src_clr = 1'b0;

    always @(posedge clk) begin
        if (src_clr)   src_ptr <= 0;
        else if (nw_a) src_ptr <= src_ptr + 1;
    end
    assign din_a = src_mem[src_ptr[2:0]];

    // ---------------- receiver / monitor, instance A ----------------
    int          cyc = 0;
    logic        p_sclk = 1'b0, p_le = 1'b0, p_data = 1'b0;
    logic [23:0] rx_sh;
    logic [23:0] rx_q [$];
    int rx_bits, nw_cnt, le_cnt, done_cnt, le_run, rise_cnt;
    int load_cyc, done_cyc, first_rise, last_nw_cyc;

    task automatic mon_clear();
        rx_q.delete();
        rx_sh = '0; rx_bits = 0; nw_cnt = 0; le_cnt = 0; done_cnt = 0;
        le_run = 0; rise_cnt = 0;
        load_cyc = -1; done_cyc = -1; first_rise = -1; last_nw_cyc = -1;
    endtask

    always @(negedge clk) begin
        cyc++;
        chk("a_le_and_sclk", 32'(le_a & sclk_a), 32'd0);
        if (data_a !== p_data) chk("a_data_chg_sclk_low", 32'(sclk_a), 32'd0);
        if (sclk_a && !p_sclk) begin
            rx_sh = {rx_sh[22:0], data_a};
            rx_bits++;
            rise_cnt++;
            if (first_rise < 0) first_rise = cyc;
        end
        if (le_a) begin
            le_run++;
        end else if (p_le) begin
            chk("a_le_width", 32'(le_run), 32'(c_LE));
            le_run = 0;
        end
        if (le_a && !p_le) begin
            chk("a_bits_per_word", 32'(rx_bits), 32'd24);
            rx_q.push_back(rx_sh);
            rx_bits = 0;
            le_cnt++;
        end
        if (nw_a) begin
            nw_cnt++;
            last_nw_cyc = cyc;
            if (load_cyc < 0) load_cyc = cyc;
        end
        if (done_a) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        p_sclk = sclk_a; p_le = le_a; p_data = data_a;
    end

    // ---------------- monitor, instance B ----------------
    logic        pb_sclk = 1'b0, pb_le = 1'b0, pb_data = 1'b0;
    logic [23:0] rxb_sh = '0;
    int rise_b = 0, leb_run = 0, leb_cnt = 0, nwb_cnt = 0, load_b = -1, done_b_cyc = -1;

    always @(negedge clk) begin
        chk("b_le_and_sclk", 32'(le_b & sclk_b), 32'd0);
        if (data_b !== pb_data) chk("b_data_chg_sclk_low", 32'(sclk_b), 32'd0);
        if (sclk_b && !pb_sclk) begin
            chk("b_data_at_rise", 32'(data_b), 32'd1);
            rxb_sh = {rxb_sh[22:0], data_b};
            rise_b++;
        end
        if (le_b) begin
            leb_run++;
        end else if (pb_le) begin
            chk("b_le_width", 32'(leb_run), 32'd1);
            leb_run = 0;
            leb_cnt++;
        end
        if (nw_b) begin
            nwb_cnt++;
            if (load_b < 0) load_b = cyc;
        end
        if (done_b && done_b_cyc < 0) done_b_cyc = cyc;
        pb_sclk = sclk_b; pb_le = le_b; pb_data = data_b;
    end

    // ---------------- helpers ----------------
    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_src();
        src_clr = 1'b1;
        cyc_wait(1);
        src_clr = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        cyc_wait(1);
        start_a = 1'b0;
    endtask

    // Runs one frame on instance A; inj > 0 pulses start again that many
    // cycles after LOAD. Expected words are the source contents in order.
    task automatic frame_a(input int inj);
        int t;
        mon_clear();
        clear_src();
        pulse_start_a();
        for (t = 0; t < c_FLEN + 20 && done_cnt == 0; t++) begin
            start_a = (inj > 0 && t == inj);
            if (t == 10) chk("busy_in_frame", 32'(busy_a), 32'd1);
            cyc_wait(1);
        end
        start_a = 1'b0;
        chk("done_seen", 32'(done_cnt), 32'd1);
        chk("done_latency", 32'(done_cyc - load_cyc), 32'(c_FLEN));
        chk("first_rise", 32'(first_rise - load_cyc), 32'(1 + c_H));
        cyc_wait(20);
        chk("busy_after", 32'(busy_a), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("next_word_count", 32'(nw_cnt), 32'(c_N));
        chk("le_count", 32'(le_cnt), 32'(c_N));
        chk("rx_count", 32'(rx_q.size()), 32'(c_N));
        for (int i = 0; i < c_N && i < rx_q.size(); i++)
            chk($sformatf("word%0d", i), 32'(rx_q[i]), 32'(src_mem[i]));
    endtask

    task automatic rand_words();
        for (int i = 0; i < 8; i++) src_mem[i] = 24'($urandom());
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int d;
        mon_clear();
        for (int i = 0; i < 8; i++) src_mem[i] = 24'h0;
        cyc_wait(3);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_le", 32'(le_a), 32'd0);
        chk("rst_nw", 32'(nw_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        RSTn = 1'b1;
        cyc_wait(5);
        chk("idle_no_activity", 32'(rise_cnt + nw_cnt), 32'd0);

        // Known six-word frame, then the same frame with a stray start.
        for (int i = 0; i < 6; i++) src_mem[i] = c_W32[i];
        frame_a(0);
        frame_a(50);

        // Reset during bit 10 of word 3 (high phase of that bit).
        rand_words();
        mon_clear();
        clear_src();
        pulse_start_a();
        cyc_wait(3 * c_WLEN + 1 + 13 * 2 * c_H + c_H);
        chk("pre_rst_sclk", 32'(sclk_a), 32'd1);
        chk("pre_rst_words", 32'(rx_q.size()), 32'd3);
        chk("pre_rst_bits", 32'(rx_bits), 32'd14);
        #2 RSTn = 1'b0;
        #1;
        chk("async_rst_sclk", 32'(sclk_a), 32'd0);
        chk("async_rst_data", 32'(data_a), 32'd0);
        chk("async_rst_le", 32'(le_a), 32'd0);
        chk("async_rst_nw", 32'(nw_a), 32'd0);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        chk("async_rst_done", 32'(done_a), 32'd0);
        cyc_wait(2);
        RSTn = 1'b1;
        mon_clear();
        cyc_wait(200);
        chk("post_rst_rises", 32'(rise_cnt), 32'd0);
        chk("post_rst_nw", 32'(nw_cnt), 32'd0);
        chk("post_rst_le", 32'(le_cnt), 32'd0);
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        frame_a(0);

        // start held through DONE starts a new frame from IDLE.
        rand_words();
        mon_clear();
        clear_src();
        start_a = 1'b1;
        for (t = 0; t < c_FLEN + 30 && done_cnt == 0; t++) cyc_wait(1);
        d = done_cyc;
        for (t = 0; t < 10 && nw_cnt <= c_N; t++) cyc_wait(1);
        chk("restart_gap", 32'(last_nw_cyc - d), 32'd2);
        start_a = 1'b0;
        for (t = 0; t < c_FLEN + 30 && done_cnt < 2; t++) cyc_wait(1);
        chk("two_frames_done", 32'(done_cnt), 32'd2);
        chk("two_frames_words", 32'(rx_q.size()), 32'(2 * c_N));
        for (int i = 0; i < 2 * c_N && i < rx_q.size(); i++)
            chk($sformatf("cont_word%0d", i), 32'(rx_q[i]), 32'(src_mem[i % 8]));
        cyc_wait(5);

        // Randomised frames with random idle gaps and stray starts.
        for (int r = 0; r < 4; r++) begin
            rand_words();
            cyc_wait($urandom_range(0, 4));
            frame_a(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, c_FLEN - 1)) : 0);
        end

        // Short-timing instance: one all-ones word.
        start_b = 1'b1;
        cyc_wait(1);
        start_b = 1'b0;
        for (t = 0; t < 80 && done_b_cyc < 0; t++) cyc_wait(1);
        chk("b_done_latency", 32'(done_b_cyc - load_b), 32'd51);
        chk("b_rises", 32'(rise_b), 32'd24);
        chk("b_word", 32'(rxb_sh), 32'h00FFFFFF);
        chk("b_nw_count", 32'(nwb_cnt), 32'd1);
        cyc_wait(5);
        chk("b_le_count", 32'(leb_cnt), 32'd1);
        chk("b_busy_after", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
